// File: rtl/my_sys_st_pkt_checker.sv
// Avalon-ST packet sink with LFSR backpressure, framing/pattern checks and a small CSR block.
// Used as a scoreboard for mSGDMA read streams.
module my_sys_st_pkt_checker #(
    parameter int unsigned DATA_W    = 512,
    parameter int unsigned EMPTY_W   = 6,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic               clock_clk,
    input  logic               reset_reset,
    input  logic [DATA_W-1:0]  st_sink_data,
    input  logic               st_sink_valid,
    output logic               st_sink_ready,
    input  logic               st_sink_startofpacket,
    input  logic               st_sink_endofpacket,
    input  logic [EMPTY_W-1:0] st_sink_empty,
    input  logic [1:0]         st_sink_error,
    input  logic [2:0]         csr_address,
    input  logic               csr_read,
    input  logic               csr_write,
    input  logic [31:0]        csr_writedata,
    input  logic [3:0]         csr_byteenable,
    output logic [31:0]        csr_readdata,
    output logic               csr_irq_irq
);

    localparam int unsigned NWORDS = DATA_W / 32;
    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned BCW    = EMPTY_W + 1;

    typedef enum logic [0:0] {StIdle, StInPkt} state_e;

    state_e      r_state, w_state_next;
    logic [7:0]  r_lfsr;
    logic        r_stall;
    logic        r_en, r_irq_pkt_en, r_irq_err_en;
    logic [7:0]  r_bp_thresh;
    logic [31:0] r_seed, r_exp, r_pkt_bytes;
    logic [31:0] r_pkt_count, r_byte_count, r_err_count, r_last_bytes;
    logic        r_st_pat, r_st_frm, r_st_err, r_st_done;
    logic [31:0] r_readdata;
    logic        r_irq;

    logic           w_xfer, w_beat, w_idle, w_sop, w_eop;
    logic           w_frm_err, w_pat_err, w_pat_bad;
    logic [31:0]    w_base, w_word, w_nbytes, w_pkt_bytes_next, w_err_inc;
    logic [BCW-1:0] w_nbytes_s;
    logic           w_clr, w_st_w1c;
    logic           w_unused_be;

    assign w_unused_be   = ^csr_byteenable;
    assign st_sink_ready = r_en & ~r_stall;
    assign csr_readdata  = r_readdata;
    assign csr_irq_irq   = r_irq;

    assign w_sop  = st_sink_startofpacket;
    assign w_eop  = st_sink_endofpacket;
    assign w_idle = (r_state == StIdle);
    assign w_xfer = st_sink_valid & st_sink_ready;
    // A non-SOP beat outside a packet is reported but otherwise ignored
    assign w_beat = w_xfer & ~(w_idle & ~w_sop);

    assign w_frm_err = w_xfer & ((w_idle & ~w_sop) | (~w_idle & w_sop) |
                                 ((st_sink_empty != '0) & ~w_eop));
    assign w_pat_err = w_beat & w_pat_bad;
    assign w_err_inc = {31'b0, w_frm_err} + {31'b0, w_pat_err};

    assign w_base     = w_sop ? r_seed : r_exp;
    assign w_nbytes_s = w_eop ? (BCW'(NBYTES) - BCW'(st_sink_empty)) : BCW'(NBYTES);
    assign w_nbytes   = {{(32 - BCW){1'b0}}, w_nbytes_s};
    assign w_pkt_bytes_next = (w_sop ? 32'd0 : r_pkt_bytes) + w_nbytes;

    assign w_clr    = csr_write & (csr_address == 3'd3);
    assign w_st_w1c = csr_write & (csr_address == 3'd0);

    always_comb begin
        w_pat_bad = 1'b0;
        w_word    = '0;
        for (int i = 0; i < NWORDS; i++) begin
            w_word = w_base + 32'(i);
            for (int b = 0; b < 4; b++) begin
                if ((BCW'(4 * i + b) < w_nbytes_s) &&
                    (st_sink_data[32*i+8*b +: 8] != w_word[8*b +: 8])) begin
                    w_pat_bad = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_xfer) begin
            unique case (r_state)
                StIdle:  if (w_sop & ~w_eop) w_state_next = StInPkt;
                StInPkt: if (w_eop)          w_state_next = StIdle;
                default: w_state_next = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock_clk) begin
        if (reset_reset) begin
            r_state      <= StIdle;
            r_lfsr       <= LFSR_SEED;
            r_stall      <= 1'b0;
            r_en         <= 1'b0;
            r_irq_pkt_en <= 1'b0;
            r_irq_err_en <= 1'b0;
            r_bp_thresh  <= '0;
            r_seed       <= '0;
            r_exp        <= '0;
            r_pkt_bytes  <= '0;
            r_pkt_count  <= '0;
            r_byte_count <= '0;
            r_err_count  <= '0;
            r_last_bytes <= '0;
            r_st_pat     <= 1'b0;
            r_st_frm     <= 1'b0;
            r_st_err     <= 1'b0;
            r_st_done    <= 1'b0;
            r_readdata   <= '0;
            r_irq        <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // x^8+x^6+x^5+x^4+1, free running
            r_lfsr  <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
            r_stall <= (r_lfsr < r_bp_thresh);

            if (w_beat) begin
                r_exp       <= w_base + 32'(NWORDS);
                r_pkt_bytes <= w_pkt_bytes_next;
            end

            if (w_clr) begin
                r_pkt_count  <= '0;
                r_byte_count <= '0;
                r_err_count  <= '0;
                r_last_bytes <= '0;
            end else begin
                r_err_count <= r_err_count + w_err_inc;
                if (w_beat) begin
                    r_byte_count <= r_byte_count + w_nbytes;
                    if (w_eop) begin
                        r_pkt_count  <= r_pkt_count + 32'd1;
                        r_last_bytes <= w_pkt_bytes_next;
                    end
                end
            end

            // W1C first, then set, so a same-cycle set survives the clear
            r_st_pat  <= (r_st_pat  & ~(w_st_w1c & csr_writedata[0])) | w_pat_err;
            r_st_frm  <= (r_st_frm  & ~(w_st_w1c & csr_writedata[1])) | w_frm_err;
            r_st_err  <= (r_st_err  & ~(w_st_w1c & csr_writedata[2])) |
                         (w_xfer & (st_sink_error != 2'b00));
            r_st_done <= (r_st_done & ~(w_st_w1c & csr_writedata[4])) | (w_beat & w_eop);

            if (csr_write && csr_address == 3'd1) begin
                r_en         <= csr_writedata[0];
                r_irq_pkt_en <= csr_writedata[1];
                r_irq_err_en <= csr_writedata[2];
                r_bp_thresh  <= csr_writedata[15:8];
            end
            if (csr_write && csr_address == 3'd2) r_seed <= csr_writedata;

            if (csr_read) begin
                unique case (csr_address)
                    3'd0: r_readdata <= {27'b0, r_st_done, ~w_idle, r_st_err, r_st_frm, r_st_pat};
                    3'd1: r_readdata <= {16'b0, r_bp_thresh, 5'b0, r_irq_err_en, r_irq_pkt_en,
                                         r_en};
                    3'd2: r_readdata <= r_seed;
                    3'd3: r_readdata <= r_pkt_count;
                    3'd4: r_readdata <= r_byte_count;
                    3'd5: r_readdata <= r_err_count;
                    3'd6: r_readdata <= r_last_bytes;
                    default: r_readdata <= 32'h5354_4348;
                endcase
            end

            r_irq <= (r_st_done & r_irq_pkt_en) |
                     ((r_st_pat | r_st_frm | r_st_err) & r_irq_err_en);
        end
    end

endmodule

// File: tb/tb_my_sys_st_pkt_checker.sv
// Self-checking bench for my_sys_st_pkt_checker: CSR reads are scored against a queue of
// expected values pushed when each read is issued.
module tb_my_sys_st_pkt_checker;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] data;
    logic         valid, ready, sop, eop;
    logic [5:0]   empty;
    logic [1:0]   err;
    logic [2:0]   addr;
    logic         rd, wr;
    logic [31:0]  wdata, rdata;
    logic [3:0]   be;
    logic         irq;

    int unsigned  n_checks = 0;
    int unsigned  n_errors = 0;
    logic [31:0]  exp_q[$];

    always #5 clk = ~clk;

    my_sys_st_pkt_checker dut (
        .clock_clk             (clk),
        .reset_reset           (rst),
        .st_sink_data          (data),
        .st_sink_valid         (valid),
        .st_sink_ready         (ready),
        .st_sink_startofpacket (sop),
        .st_sink_endofpacket   (eop),
        .st_sink_empty         (empty),
        .st_sink_error         (err),
        .csr_address           (addr),
        .csr_read              (rd),
        .csr_write             (wr),
        .csr_writedata         (wdata),
        .csr_byteenable        (be),
        .csr_readdata          (rdata),
        .csr_irq_irq           (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, expv);
        end
    endtask

    function automatic logic [511:0] mk_beat(input logic [31:0] base);
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = base + 32'(i);
        return d;
    endfunction

    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic csr_rd(input string tag, input logic [2:0] a, input logic [31:0] expv);
        @(negedge clk);
        rd = 1'b1; addr = a;
        exp_q.push_back(expv);
        @(negedge clk);
        rd = 1'b0;
        check(tag, rdata, exp_q.pop_front());
    endtask

    task automatic send_beat(input logic [511:0] d, input logic s, input logic e,
                             input logic [5:0] em, input logic [1:0] er);
        int cnt;
        @(negedge clk);
        valid = 1'b1; data = d; sop = s; eop = e; empty = em; err = er;
        cnt = 0;
        while (!ready && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 200) check("beat_timeout", 32'(ready), 32'd1);
        @(posedge clk);
        #1;
        valid = 1'b0; sop = 1'b0; eop = 1'b0; empty = '0; err = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] d;
        int           nxf, nrdy;

        rst = 1'b1; valid = 1'b0; sop = 1'b0; eop = 1'b0; empty = '0; err = '0;
        data = '0; addr = '0; rd = 1'b0; wr = 1'b0; wdata = '0; be = 4'hF;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        csr_rd("rst_status", 3'd0, 32'h0);
        csr_rd("rst_ctrl", 3'd1, 32'h0);
        csr_rd("rst_seed", 3'd2, 32'h0);
        csr_rd("rst_pkt", 3'd3, 32'h0);
        csr_rd("id", 3'd7, 32'h5354_4348);
        csr_wr(3'd1, 32'hFFFF_FFFF);
        csr_rd("ctrl_mask", 3'd1, 32'h0000_FF07);
        csr_wr(3'd1, 32'h0);

        // 1: three-beat packet, words 0..47, empty=4 on EOP
        csr_wr(3'd2, 32'h0);
        csr_wr(3'd1, 32'h1);
        send_beat(mk_beat(32'd0), 1'b1, 1'b0, 6'd0, 2'd0);
        send_beat(mk_beat(32'd16), 1'b0, 1'b0, 6'd0, 2'd0);
        send_beat(mk_beat(32'd32), 1'b0, 1'b1, 6'd4, 2'd0);
        csr_rd("t1_pkt", 3'd3, 32'd1);
        csr_rd("t1_byte", 3'd4, 32'd188);
        csr_rd("t1_last", 3'd6, 32'd188);
        csr_rd("t1_status", 3'd0, 32'h10);
        csr_rd("t1_err", 3'd5, 32'd0);
        csr_wr(3'd0, 32'h10);

        // 2: single-beat packet, one valid byte; corrupt byte1 must be ignored
        csr_wr(3'd2, 32'h1234_5678);
        csr_rd("t2_seed", 3'd2, 32'h1234_5678);
        d = mk_beat(32'h1234_5678);
        d[15:8] = ~d[15:8];
        send_beat(d, 1'b1, 1'b1, 6'd63, 2'd0);
        csr_rd("t2_byte", 3'd4, 32'd189);
        csr_rd("t2_last", 3'd6, 32'd1);
        csr_rd("t2_status", 3'd0, 32'h10);
        csr_rd("t2_err", 3'd5, 32'd0);
        csr_wr(3'd0, 32'h10);

        // 3: word 17 corrupted, error irq one cycle after status
        csr_wr(3'd2, 32'h0);
        csr_wr(3'd1, 32'h5);
        send_beat(mk_beat(32'd0), 1'b1, 1'b0, 6'd0, 2'd0);
        d = mk_beat(32'd16);
        d[63:32] = d[63:32] ^ 32'h1;
        send_beat(d, 1'b0, 1'b1, 6'd0, 2'd0);
        check("t3_irq_early", 32'(irq), 32'd0);
        @(posedge clk);
        #1 check("t3_irq_rise", 32'(irq), 32'd1);
        csr_rd("t3_status", 3'd0, 32'h11);
        csr_rd("t3_err", 3'd5, 32'd1);
        csr_rd("t3_pkt", 3'd3, 32'd3);
        csr_wr(3'd0, 32'h1);
        @(negedge clk);
        check("t3_irq_drop", 32'(irq), 32'd0);
        csr_wr(3'd0, 32'h10);

        // 4: framing errors
        csr_wr(3'd3, 32'h0);
        csr_wr(3'd1, 32'h1);
        send_beat(mk_beat(32'd0), 1'b0, 1'b0, 6'd0, 2'd0);
        csr_rd("t4_status_a", 3'd0, 32'h02);
        csr_rd("t4_byte_a", 3'd4, 32'd0);
        csr_rd("t4_err_a", 3'd5, 32'd1);
        csr_wr(3'd0, 32'h2);
        send_beat(mk_beat(32'd0), 1'b1, 1'b0, 6'd0, 2'd0);
        csr_rd("t4_inpkt", 3'd0, 32'h08);
        send_beat(mk_beat(32'd0), 1'b1, 1'b0, 6'd0, 2'd0);
        csr_rd("t4_status_b", 3'd0, 32'h0A);
        send_beat(mk_beat(32'd16), 1'b0, 1'b1, 6'd0, 2'd0);
        csr_rd("t4_err_b", 3'd5, 32'd2);
        csr_rd("t4_pkt_b", 3'd3, 32'd1);
        csr_rd("t4_last_b", 3'd6, 32'd128);
        csr_rd("t4_byte_b", 3'd4, 32'd192);
        csr_rd("t4_status_c", 3'd0, 32'h12);
        csr_wr(3'd0, 32'h1F);
        send_beat(mk_beat(32'd0), 1'b1, 1'b0, 6'd5, 2'd0);
        send_beat(mk_beat(32'd16), 1'b0, 1'b1, 6'd0, 2'd1);
        csr_rd("t4_err_c", 3'd5, 32'd3);
        csr_rd("t4_byte_c", 3'd4, 32'd320);
        csr_rd("t4_status_d", 3'd0, 32'h16);
        csr_wr(3'd0, 32'h1F);

        // 5: LFSR backpressure with valid held high
        csr_wr(3'd2, 32'h40);
        csr_wr(3'd3, 32'h0);
        csr_wr(3'd1, 32'h8001);
        nxf = 0;
        @(negedge clk);
        valid = 1'b1; sop = 1'b1; eop = 1'b1; empty = '0; data = mk_beat(32'h40);
        for (int i = 0; i < 1000; i++) begin
            if (ready) nxf++;
            @(negedge clk);
        end
        valid = 1'b0; sop = 1'b0; eop = 1'b0;
        check("t5_ratio", 32'(nxf > 300 && nxf < 700), 32'd1);
        csr_rd("t5_pkt", 3'd3, 32'(nxf));
        csr_rd("t5_byte", 3'd4, 32'(nxf * 64));
        csr_rd("t5_err", 3'd5, 32'd0);
        csr_rd("t5_last", 3'd6, 32'd64);
        csr_wr(3'd1, 32'h8000);
        nrdy = 0;
        valid = 1'b1; sop = 1'b1; eop = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (ready) nrdy++;
            @(negedge clk);
        end
        valid = 1'b0; sop = 1'b0; eop = 1'b0;
        check("t5_ready_dis", 32'(nrdy), 32'd0);
        csr_rd("t5_pkt_dis", 3'd3, 32'(nxf));

        // 6: counter clear in the same cycle as EOP
        csr_wr(3'd1, 32'h1);
        csr_wr(3'd0, 32'h1F);
        send_beat(mk_beat(32'h40), 1'b1, 1'b0, 6'd0, 2'd0);
        @(negedge clk);
        check("t6_ready", 32'(ready), 32'd1);
        valid = 1'b1; data = mk_beat(32'h50); sop = 1'b0; eop = 1'b1; empty = '0;
        wr = 1'b1; addr = 3'd3; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        valid = 1'b0; eop = 1'b0; wr = 1'b0;
        csr_rd("t6_pkt", 3'd3, 32'd0);
        csr_rd("t6_byte", 3'd4, 32'd0);
        csr_rd("t6_err", 3'd5, 32'd0);
        csr_rd("t6_last", 3'd6, 32'd0);
        csr_rd("t6_status", 3'd0, 32'h10);

        // Reset mid-packet
        csr_wr(3'd0, 32'h1F);
        send_beat(mk_beat(32'h40), 1'b1, 1'b0, 6'd0, 2'd0);
        csr_rd("rst2_inpkt", 3'd0, 32'h08);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst2_ready", 32'(ready), 32'd0);
        csr_rd("rst2_status", 3'd0, 32'h0);
        csr_rd("rst2_seed", 3'd2, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
